// File: rtl/mul_div_unit_if.sv
// Operand/result bundle between the register-file read path and mul_div_unit.
interface mul_div_unit_if;
   logic        Start;
   logic [1:0]  Op;
   logic [31:0] busA;
   logic [31:0] busB;
   logic        Busy;
   logic        Done;
   logic [31:0] Hi;
   logic [31:0] Lo;

   modport master (output Start, Op, busA, busB, input Busy, Done, Hi, Lo);
   modport slave  (input Start, Op, busA, busB, output Busy, Done, Hi, Lo);
endinterface

// File: rtl/mul_div_unit.sv
// Iterative 32-bit MULTU/MULT/DIVU/DIV unit: 32 shift-add or restoring-divide steps, Hi/Lo result registers.
// Optional MULDIV_EARLY_DIV0_EN: divide by zero bypasses the iteration phase and finishes one edge after acceptance.
module mul_div_unit (
   input logic           Clock,
   input logic           Reset,
   mul_div_unit_if.slave bus
);
   localparam int unsigned W  = 32;
   localparam int unsigned DW = 2 * W;
   localparam int unsigned CW = 6;
   localparam logic [CW-1:0] LAST = CW'(W - 1);

   typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

   state_t          state, state_nx;
   logic [1:0]      op, op_nx;
   logic [DW-1:0]   acc, acc_nx;
   logic [W-1:0]    opnd, opnd_nx;
   logic [W-1:0]    orig_a, orig_a_nx;
   logic            neg_q, neg_q_nx;
   logic            neg_r, neg_r_nx;
   logic            div0, div0_nx;
   logic [CW-1:0]   cnt, cnt_nx;
   logic            busy, busy_nx;
   logic            done, done_nx;
   logic [W-1:0]    hi, hi_nx;
   logic [W-1:0]    lo, lo_nx;

   logic            sgn_a, sgn_b, b_zero;
   logic [W-1:0]    abs_a, abs_b;
   logic [W:0]      mul_sum, div_trial, div_diff;
   logic [DW-1:0]   prod_fix;
   logic [W-1:0]    q_fix, r_fix;

   assign sgn_a  = bus.Op[0] & bus.busA[W-1];
   assign sgn_b  = bus.Op[0] & bus.busB[W-1];
   assign abs_a  = sgn_a ? W'(-bus.busA) : bus.busA;
   assign abs_b  = sgn_b ? W'(-bus.busB) : bus.busB;
   assign b_zero = (bus.busB == '0);

   // acc holds {partial product, remaining multiplier} or {partial remainder, dividend/quotient}
   assign mul_sum   = {1'b0, acc[DW-1:W]} + (acc[0] ? {1'b0, opnd} : {(W+1){1'b0}});
   assign div_trial = {acc[DW-1:W], acc[W-1]};
   assign div_diff  = div_trial - {1'b0, opnd};

   assign prod_fix = neg_q ? DW'(-acc) : acc;
   assign q_fix    = neg_q ? W'(-acc[W-1:0]) : acc[W-1:0];
   assign r_fix    = neg_r ? W'(-acc[DW-1:W]) : acc[DW-1:W];

   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) begin
         state  <= IDLE;
         op     <= '0;
         acc    <= '0;
         opnd   <= '0;
         orig_a <= '0;
         neg_q  <= 1'b0;
         neg_r  <= 1'b0;
         div0   <= 1'b0;
         cnt    <= '0;
         busy   <= 1'b0;
         done   <= 1'b0;
         hi     <= '0;
         lo     <= '0;
      end else begin
         state  <= state_nx;
         op     <= op_nx;
         acc    <= acc_nx;
         opnd   <= opnd_nx;
         orig_a <= orig_a_nx;
         neg_q  <= neg_q_nx;
         neg_r  <= neg_r_nx;
         div0   <= div0_nx;
         cnt    <= cnt_nx;
         busy   <= busy_nx;
         done   <= done_nx;
         hi     <= hi_nx;
         lo     <= lo_nx;
      end
   end

   always_comb begin
      state_nx  = state;
      op_nx     = op;
      acc_nx    = acc;
      opnd_nx   = opnd;
      orig_a_nx = orig_a;
      neg_q_nx  = neg_q;
      neg_r_nx  = neg_r;
      div0_nx   = div0;
      cnt_nx    = cnt;
      busy_nx   = busy;
      done_nx   = 1'b0;
      hi_nx     = hi;
      lo_nx     = lo;

      unique case (state)
         IDLE: begin
            if (bus.Start) begin
               op_nx     = bus.Op;
               orig_a_nx = bus.busA;
               div0_nx   = bus.Op[1] & b_zero;
               neg_q_nx  = sgn_a ^ sgn_b;
               neg_r_nx  = sgn_a;
               cnt_nx    = '0;
               busy_nx   = 1'b1;
               if (bus.Op[1]) begin
                  acc_nx  = {W'(0), abs_a};
                  opnd_nx = abs_b;
               end else begin
                  acc_nx  = {W'(0), abs_b};
                  opnd_nx = abs_a;
               end
`ifdef MULDIV_EARLY_DIV0_EN
               state_nx = (bus.Op[1] && b_zero) ? FIX : RUN;
`else
               state_nx = RUN;
`endif
            end
         end
         RUN: begin
            cnt_nx = cnt + 1'b1;
            if (op[1]) begin
               if (!div_diff[W]) acc_nx = {div_diff[W-1:0], acc[W-2:0], 1'b1};
               else              acc_nx = {div_trial[W-1:0], acc[W-2:0], 1'b0};
            end else begin
               acc_nx = {mul_sum, acc[W-1:1]};
            end
            if (cnt == LAST) state_nx = FIX;
         end
         FIX: begin
            state_nx = IDLE;
            busy_nx  = 1'b0;
            done_nx  = 1'b1;
            if (div0) begin
               hi_nx = orig_a;
               lo_nx = '1;
            end else if (op[1]) begin
               hi_nx = r_fix;
               lo_nx = q_fix;
            end else begin
               hi_nx = prod_fix[DW-1:W];
               lo_nx = prod_fix[W-1:0];
            end
         end
         default: state_nx = IDLE;
      endcase
   end

   assign bus.Busy = busy;
   assign bus.Done = done;
   assign bus.Hi   = hi;
   assign bus.Lo   = lo;
endmodule

// File: tb/tb_mul_div_unit.sv
// Self-checking bench for mul_div_unit: directed literal cases plus randomized traffic against an arithmetic model.
module tb_mul_div_unit;
   logic Clock = 1'b0;
   logic Reset;

   mul_div_unit_if bus();

   mul_div_unit dut (
      .Clock (Clock),
      .Reset (Reset),
      .bus   (bus)
   );

   always #5 Clock = ~Clock;

`ifdef MULDIV_EARLY_DIV0_EN
   localparam int DIV0_LAT = 1;
`else
   localparam int DIV0_LAT = 33;
`endif

   int n_assert = 0;
   int n_fail   = 0;

   task automatic check(input string name, input logic [65:0] act, input logic [65:0] exp);
      n_assert++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Result as {Hi, Lo} straight from the arithmetic definition of each op.
   function automatic logic [63:0] ref_result(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
      longint sa, sb, p;
      int     ia, ib;
      case (op)
         2'b00: ref_result = {32'h0, a} * {32'h0, b};
         2'b01: begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
            p  = sa * sb;
            ref_result = 64'(p);
         end
         2'b10: ref_result = (b == 0) ? {a, 32'hFFFF_FFFF} : {a % b, a / b};
         default: begin
            ia = int'(a);
            ib = int'(b);
            if (b == 0)                                  ref_result = {a, 32'hFFFF_FFFF};
            else if (a == 32'h8000_0000 && b == '1)      ref_result = {32'h0, 32'h8000_0000};
            else                                         ref_result = {32'(ia % ib), 32'(ia / ib)};
         end
      endcase
   endfunction

   function automatic int ref_lat(input logic [1:0] op, input logic [31:0] b);
      ref_lat = (op[1] && b == 0) ? DIV0_LAT : 33;
   endfunction

   // Cycle-level scoreboard: accepted op finishes ref_lat edges later.
   logic        m_busy, m_done;
   logic [31:0] m_hi, m_lo;
   logic [63:0] m_pend;
   int          m_rem;

   always @(posedge Clock or posedge Reset) begin
      if (Reset) begin
         m_busy = 1'b0;
         m_done = 1'b0;
         m_hi   = '0;
         m_lo   = '0;
         m_rem  = 0;
      end else begin
         m_done = 1'b0;
         if (m_busy) begin
            m_rem--;
            if (m_rem == 0) begin
               m_busy = 1'b0;
               m_done = 1'b1;
               {m_hi, m_lo} = m_pend;
            end
         end else if (bus.Start === 1'b1) begin
            m_pend = ref_result(bus.Op, bus.busA, bus.busB);
            m_rem  = ref_lat(bus.Op, bus.busB);
            m_busy = 1'b1;
         end
      end
   end

   always @(negedge Clock) begin
      if (Reset === 1'b0)
         check("cycle_compare", {bus.Busy, bus.Done, bus.Hi, bus.Lo}, {m_busy, m_done, m_hi, m_lo});
   end

   function automatic logic [31:0] pick();
      case ($urandom % 8)
         0:       pick = 32'h0;
         1:       pick = 32'h8000_0000;
         2:       pick = 32'hFFFF_FFFF;
         3:       pick = 32'($urandom % 16);
         default: pick = $urandom;
      endcase
   endfunction

   // Issue one op from the current cycle, optionally poke Start while busy, then wait for Done.
   task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp_hi, input logic [31:0] exp_lo,
                         input int exp_lat, input int poke_cyc, input string name);
      int lat;
      lat = -1;
      bus.Start = 1'b1;
      bus.Op    = op;
      bus.busA  = a;
      bus.busB  = b;
      @(posedge Clock); #2;
      bus.Start = 1'b0;
      bus.Op    = 2'($urandom);
      bus.busA  = $urandom;
      bus.busB  = $urandom;
      for (int c = 1; c <= 40; c++) begin
         @(posedge Clock); #2;
         bus.Start = (c == poke_cyc);
         if (bus.Done === 1'b1) begin
            lat = c;
            break;
         end
      end
      bus.Start = 1'b0;
      check({name, "_lat"}, 66'(lat), 66'(exp_lat));
      check({name, "_hi"}, 66'(bus.Hi), 66'(exp_hi));
      check({name, "_lo"}, 66'(bus.Lo), 66'(exp_lo));
   endtask

   initial begin
      int dones;
      Reset     = 1'b1;
      bus.Start = 1'b0;
      bus.Op    = '0;
      bus.busA  = '0;
      bus.busB  = '0;

      // Pin the model with hand-computed values.
      check("model_multu", 66'(ref_result(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF)), 66'(64'hFFFF_FFFE_0000_0001));
      check("model_mult",  66'(ref_result(2'b01, 32'hFFFF_FFFD, 32'd5)), 66'(64'hFFFF_FFFF_FFFF_FFF1));
      check("model_div",   66'(ref_result(2'b11, 32'hFFFF_FFF9, 32'd2)), 66'(64'hFFFF_FFFF_FFFF_FFFD));
      check("model_divu",  66'(ref_result(2'b10, 32'd100, 32'd7)), 66'(64'h0000_0002_0000_000E));

      repeat (3) @(posedge Clock);
      #2;
      check("reset_state", {bus.Busy, bus.Done, bus.Hi, bus.Lo}, 66'h0);
      Reset = 1'b0;
      @(posedge Clock); #2;

      run_op(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 33, 0, "multu_max");
      run_op(2'b01, 32'hFFFF_FFFD, 32'd5, 32'hFFFF_FFFF, 32'hFFFF_FFF1, 33, 0, "mult_neg");
      run_op(2'b10, 32'd100, 32'd7, 32'd2, 32'd14, 33, 0, "divu_b2b");
      run_op(2'b11, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 33, 0, "div_neg");
      run_op(2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000, 33, 0, "div_ovf");
      run_op(2'b10, 32'h1234_5678, 32'h0, 32'h1234_5678, 32'hFFFF_FFFF, DIV0_LAT, 0, "divu_zero");
      run_op(2'b11, 32'hFFFF_FFF0, 32'h0, 32'hFFFF_FFF0, 32'hFFFF_FFFF, DIV0_LAT, 0, "div_zero");
      run_op(2'b00, 32'd3, 32'd7, 32'd0, 32'd21, 33, 5, "multu_poke");

      // Reset in the middle of an operation.
      bus.Start = 1'b1;
      bus.Op    = 2'b00;
      bus.busA  = 32'hDEAD_BEEF;
      bus.busB  = 32'h1234_5678;
      @(posedge Clock); #2;
      bus.Start = 1'b0;
      repeat (10) @(posedge Clock);
      #2;
      Reset = 1'b1;
      #1;
      check("reset_abort", {bus.Busy, bus.Done, bus.Hi, bus.Lo}, 66'h0);
      @(posedge Clock); #2;
      Reset = 1'b0;
      dones = 0;
      for (int c = 0; c < 40; c++) begin
         @(posedge Clock); #2;
         if (bus.Done === 1'b1) dones++;
      end
      check("no_done_after_reset", 66'(dones), 66'h0);

      // Randomized traffic; the per-cycle compare does the checking.
      for (int i = 0; i < 5000; i++) begin
         @(posedge Clock); #2;
         bus.Start = (($urandom % 4) == 0);
         bus.Op    = 2'($urandom);
         bus.busA  = pick();
         bus.busB  = pick();
         if (i == 2500) Reset = 1'b1;
         if (i == 2502) Reset = 1'b0;
      end
      bus.Start = 1'b0;
      repeat (40) @(posedge Clock);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end
endmodule
